// File: rtl/dominos_input_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : dominos_input_ctrl
//  Function : PS/2 + joystick input conditioning for the Dominos core;
//             held-key decode, registered controls, one-shot coin pulses.
//  Revision : 1.0  initial release
// ============================================================================
module dominos_input_ctrl #(
    parameter int COIN_HOLD = 1200000,
    parameter int COIN_GAP  = 600000
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic [10:0] ps2_key,
    input  logic [15:0] joy0,
    input  logic [15:0] joy1,
    input  logic        kb_flush,
    output logic        up1_n,
    output logic        down1_n,
    output logic        left1_n,
    output logic        right1_n,
    output logic        up2_n,
    output logic        down2_n,
    output logic        left2_n,
    output logic        right2_n,
    output logic        start1_n,
    output logic        start2_n,
    output logic        coin1_n,
    output logic        coin2_n
);

    localparam int c_CNT_MAX = (COIN_HOLD > COIN_GAP) ? COIN_HOLD : COIN_GAP;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);
    localparam logic [c_CNT_W-1:0] c_HOLD_LD = c_CNT_W'(COIN_HOLD - 1);
    localparam logic [c_CNT_W-1:0] c_GAP_LD  = c_CNT_W'(COIN_GAP - 1);

    localparam int c_K_UP1     = 0;
    localparam int c_K_DOWN1   = 1;
    localparam int c_K_LEFT1   = 2;
    localparam int c_K_RIGHT1  = 3;
    localparam int c_K_UP2     = 4;
    localparam int c_K_DOWN2   = 5;
    localparam int c_K_LEFT2   = 6;
    localparam int c_K_RIGHT2  = 7;
    localparam int c_K_COIN1A  = 8;
    localparam int c_K_COIN1B  = 9;
    localparam int c_K_COIN2A  = 10;
    localparam int c_K_COIN2B  = 11;
    localparam int c_K_START1A = 12;
    localparam int c_K_START1B = 13;
    localparam int c_K_START2A = 14;
    localparam int c_K_START2B = 15;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACTIVE  = 2'd1,
        S_GAP     = 2'd2,
        S_RELEASE = 2'd3
    } coin_state_t;

    logic        r_tog_q;
    logic        r_primed;
    logic [15:0] r_keys;
    logic [15:0] w_key_sel;
    logic        w_event;
    logic [1:0]  w_coin_req;
    logic        w_unused;

    assign w_unused = &{1'b0, joy0[15:8], joy1[15:8]};

    // The first edge after reset only captures the toggle level, so a key
    // already latched in hps_io is not replayed as a fresh event.
    assign w_event = r_primed && (r_tog_q != ps2_key[10]);

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_tog_q  <= 1'b0;
            r_primed <= 1'b0;
        end else begin
            r_tog_q  <= ps2_key[10];
            r_primed <= 1'b1;
        end
    end

    always_comb begin
        w_key_sel = '0;
        case (ps2_key[7:0])
            8'h75: w_key_sel[c_K_UP1]     = 1'b1;
            8'h72: w_key_sel[c_K_DOWN1]   = 1'b1;
            8'h6B: w_key_sel[c_K_LEFT1]   = 1'b1;
            8'h74: w_key_sel[c_K_RIGHT1]  = 1'b1;
            8'h29: w_key_sel[c_K_COIN1A]  = !ps2_key[8];
            8'h2E: w_key_sel[c_K_COIN1B]  = !ps2_key[8];
            8'h14: w_key_sel[c_K_COIN2A]  = !ps2_key[8];
            8'h36: w_key_sel[c_K_COIN2B]  = !ps2_key[8];
            8'h05: w_key_sel[c_K_START1A] = !ps2_key[8];
            8'h16: w_key_sel[c_K_START1B] = !ps2_key[8];
            8'h06: w_key_sel[c_K_START2A] = !ps2_key[8];
            8'h1E: w_key_sel[c_K_START2B] = !ps2_key[8];
            8'h2D: w_key_sel[c_K_UP2]     = !ps2_key[8];
            8'h2B: w_key_sel[c_K_DOWN2]   = !ps2_key[8];
            8'h23: w_key_sel[c_K_LEFT2]   = !ps2_key[8];
            8'h34: w_key_sel[c_K_RIGHT2]  = !ps2_key[8];
            default: ;
        endcase
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_keys <= '0;
        end else if (kb_flush) begin
            r_keys <= '0;
        end else if (w_event) begin
            r_keys <= (r_keys & ~w_key_sel) | (w_key_sel & {16{ps2_key[9]}});
        end
    end

    assign w_coin_req[0] = r_keys[c_K_COIN1A] | r_keys[c_K_COIN1B]
                         | joy0[4] | joy0[7] | joy1[7];
    assign w_coin_req[1] = r_keys[c_K_COIN2A] | r_keys[c_K_COIN2B] | joy1[4];

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            up1_n    <= 1'b1;
            down1_n  <= 1'b1;
            left1_n  <= 1'b1;
            right1_n <= 1'b1;
            up2_n    <= 1'b1;
            down2_n  <= 1'b1;
            left2_n  <= 1'b1;
            right2_n <= 1'b1;
            start1_n <= 1'b1;
            start2_n <= 1'b1;
        end else begin
            up1_n    <= ~(r_keys[c_K_UP1]    | joy0[3]);
            down1_n  <= ~(r_keys[c_K_DOWN1]  | joy0[2]);
            left1_n  <= ~(r_keys[c_K_LEFT1]  | joy0[1]);
            right1_n <= ~(r_keys[c_K_RIGHT1] | joy0[0]);
            up2_n    <= ~(r_keys[c_K_UP2]    | joy1[3]);
            down2_n  <= ~(r_keys[c_K_DOWN2]  | joy1[2]);
            left2_n  <= ~(r_keys[c_K_LEFT2]  | joy1[1]);
            right2_n <= ~(r_keys[c_K_RIGHT2] | joy1[0]);
            start1_n <= ~(r_keys[c_K_START1A] | r_keys[c_K_START1B] | joy0[5] | joy1[5]);
            start2_n <= ~(r_keys[c_K_START2A] | r_keys[c_K_START2B] | joy0[6] | joy1[6]);
        end
    end

    // One shaper per coin channel; a held request must be seen low in
    // RELEASE before another pulse can start.
    for (genvar gi = 0; gi < 2; gi++) begin : g_coin
        coin_state_t        r_state;
        logic [c_CNT_W-1:0] r_cnt;
        logic               r_coin_n;

        always_ff @(posedge clk_sys or posedge reset) begin
            if (reset) begin
                r_state  <= S_IDLE;
                r_cnt    <= '0;
                r_coin_n <= 1'b1;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_coin_req[gi]) begin
                            r_state  <= S_ACTIVE;
                            r_cnt    <= c_HOLD_LD;
                            r_coin_n <= 1'b0;
                        end
                    end
                    S_ACTIVE: begin
                        if (r_cnt == '0) begin
                            r_state  <= S_GAP;
                            r_cnt    <= c_GAP_LD;
                            r_coin_n <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                    S_GAP: begin
                        if (r_cnt == '0) begin
                            r_state <= S_RELEASE;
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                    S_RELEASE: begin
                        if (!w_coin_req[gi]) begin
                            r_state <= S_IDLE;
                        end
                    end
                    default: begin
                        r_state  <= S_IDLE;
                        r_coin_n <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign coin1_n = g_coin[0].r_coin_n;
    assign coin2_n = g_coin[1].r_coin_n;

endmodule
`default_nettype wire

// File: tb/tb_dominos_input_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dominos_input_ctrl
//  Function : directed + random bench for dominos_input_ctrl against a
//             key-map / pulse-timer reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_dominos_input_ctrl;

    localparam int HOLD = 4;
    localparam int GAP  = 3;

    logic        clk_sys  = 1'b0;
    logic        reset    = 1'b1;
    logic [10:0] ps2_key  = 11'h400;
    logic [15:0] joy0     = '0;
    logic [15:0] joy1     = '0;
    logic        kb_flush = 1'b0;
    logic up1_n, down1_n, left1_n, right1_n;
    logic up2_n, down2_n, left2_n, right2_n;
    logic start1_n, start2_n, coin1_n, coin2_n;

    int n_checks = 0;
    int n_errors = 0;
    int c1_lows  = 0;
    int c2_lows  = 0;

    // Reference model: held state per scancode, pulse timers per coin channel.
    bit         m_kb [0:255];
    logic       m_tog;
    bit         m_primed;
    int         m_busy [2];
    bit         m_need_low [2];
    logic [11:0] m_out;

    logic [7:0] codes [0:17] = '{8'h75, 8'h72, 8'h6B, 8'h74, 8'h29, 8'h2E,
                                 8'h14, 8'h36, 8'h05, 8'h16, 8'h06, 8'h1E,
                                 8'h2D, 8'h2B, 8'h23, 8'h34, 8'h1C, 8'h5A};

    dominos_input_ctrl #(.COIN_HOLD(HOLD), .COIN_GAP(GAP)) dut (
        .clk_sys (clk_sys),
        .reset   (reset),
        .ps2_key (ps2_key),
        .joy0    (joy0),
        .joy1    (joy1),
        .kb_flush(kb_flush),
        .up1_n   (up1_n),
        .down1_n (down1_n),
        .left1_n (left1_n),
        .right1_n(right1_n),
        .up2_n   (up2_n),
        .down2_n (down2_n),
        .left2_n (left2_n),
        .right2_n(right2_n),
        .start1_n(start1_n),
        .start2_n(start2_n),
        .coin1_n (coin1_n),
        .coin2_n (coin2_n)
    );

    initial forever #5 clk_sys = ~clk_sys;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 256; i++) m_kb[i] = 1'b0;
        m_tog    = 1'b0;
        m_primed = 1'b0;
        m_busy   = '{0, 0};
        m_need_low = '{1'b0, 1'b0};
        m_out    = '1;
    endtask

    task automatic model_step();
        logic [9:0] held;
        logic [1:0] req;
        logic [7:0] code;
        if (reset) begin
            model_reset();
            return;
        end
        held[9] = m_kb[8'h75] | joy0[3];
        held[8] = m_kb[8'h72] | joy0[2];
        held[7] = m_kb[8'h6B] | joy0[1];
        held[6] = m_kb[8'h74] | joy0[0];
        held[5] = m_kb[8'h2D] | joy1[3];
        held[4] = m_kb[8'h2B] | joy1[2];
        held[3] = m_kb[8'h23] | joy1[1];
        held[2] = m_kb[8'h34] | joy1[0];
        held[1] = m_kb[8'h05] | m_kb[8'h16] | joy0[5] | joy1[5];
        held[0] = m_kb[8'h06] | m_kb[8'h1E] | joy0[6] | joy1[6];
        req[0]  = m_kb[8'h29] | m_kb[8'h2E] | joy0[4] | joy0[7] | joy1[7];
        req[1]  = m_kb[8'h14] | m_kb[8'h36] | joy1[4];
        for (int c = 0; c < 2; c++) begin
            if (m_busy[c] > 0) begin
                m_busy[c]--;
                if (m_busy[c] == 0) m_need_low[c] = 1'b1;
            end else if (m_need_low[c]) begin
                if (!req[c]) m_need_low[c] = 1'b0;
            end else if (req[c]) begin
                m_busy[c] = HOLD + GAP;
            end
        end
        m_out = {~held, (m_busy[0] > GAP) ? 1'b0 : 1'b1, (m_busy[1] > GAP) ? 1'b0 : 1'b1};
        code = ps2_key[7:0];
        if (!m_primed) begin
            m_primed = 1'b1;
        end else if (m_tog != ps2_key[10] && !kb_flush) begin
            if (code inside {8'h75, 8'h72, 8'h6B, 8'h74})
                m_kb[code] = ps2_key[9];
            else if (!ps2_key[8] && code inside {8'h29, 8'h2E, 8'h14, 8'h36, 8'h05, 8'h16,
                                                 8'h06, 8'h1E, 8'h2D, 8'h2B, 8'h23, 8'h34})
                m_kb[code] = ps2_key[9];
        end
        m_tog = ps2_key[10];
        if (kb_flush) for (int i = 0; i < 256; i++) m_kb[i] = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk_sys);
        model_step();
        #1;
        check("outs", {up1_n, down1_n, left1_n, right1_n, up2_n, down2_n, left2_n, right2_n,
                       start1_n, start2_n, coin1_n, coin2_n}, m_out);
        if (!coin1_n) c1_lows++;
        if (!coin2_n) c2_lows++;
    endtask

    task automatic key(input logic pressed, input logic [8:0] code);
        ps2_key = {~ps2_key[10], pressed, code};
    endtask

    initial begin
        model_reset();
        // reset priming with toggle already high
        tick(); tick();
        check("reset_outs", {up1_n, down1_n, left1_n, right1_n, up2_n, down2_n, left2_n,
                             right2_n, start1_n, start2_n, coin1_n, coin2_n}, 12'hFFF);
        reset = 1'b0;
        repeat (5) tick();
        check("primed_quiet", {up1_n, down1_n, left1_n, right1_n, up2_n, down2_n, left2_n,
                               right2_n, start1_n, start2_n, coin1_n, coin2_n}, 12'hFFF);
        key(1'b1, 9'h075); tick(); tick();
        check("up1_press", up1_n, 0);
        key(1'b0, 9'h075); tick(); tick();
        check("up1_release", up1_n, 1);

        // extended-key gating
        key(1'b1, 9'h029); c1_lows = 0;
        repeat (12) tick();
        check("coin_key_width", c1_lows, HOLD);
        key(1'b0, 9'h029); repeat (3) tick();
        key(1'b1, 9'h129); c1_lows = 0;
        repeat (12) tick();
        check("ext_coin_gated", c1_lows, 0);
        key(1'b1, 9'h175); tick(); tick();
        check("up1_ext", up1_n, 0);
        key(1'b0, 9'h075); tick(); tick();

        // held-coin one-shot and re-press
        joy0[4] = 1'b1; c1_lows = 0;
        repeat (20) tick();
        check("held_one_shot", c1_lows, HOLD);
        joy0[4] = 1'b0; tick(); tick();
        joy0[4] = 1'b1; tick();
        check("coin_repress", coin1_n, 0);
        joy0[4] = 1'b0; repeat (10) tick();
        joy0[4] = 1'b1; c1_lows = 0; tick();
        joy0[4] = 1'b0; repeat (3) tick();
        joy0[4] = 1'b1; repeat (15) tick();
        check("regress_no_second", c1_lows, HOLD);
        joy0[4] = 1'b0; tick(); tick();
        joy0[4] = 1'b1; tick();
        check("coin_after_release", coin1_n, 0);
        joy0[4] = 1'b0; repeat (10) tick();

        // flush beats a same-cycle press
        key(1'b1, 9'h02D); tick(); tick();
        check("up2_held", up2_n, 0);
        kb_flush = 1'b1; key(1'b1, 9'h034); tick();
        kb_flush = 1'b0; tick();
        check("flush_wins", {up2_n, right2_n}, 2'b11);

        // asynchronous reset mid-pulse
        joy1[4] = 1'b1; tick();
        check("coin2_start", coin2_n, 0);
        tick(); tick();
        reset = 1'b1; model_reset(); #1;
        check("coin2_async_reset", coin2_n, 1);
        joy1[4] = 1'b0; tick(); tick();
        reset = 1'b0;
        joy1[4] = 1'b1; c2_lows = 0; tick();
        check("coin2_fresh_start", coin2_n, 0);
        repeat (9) tick();
        check("coin2_fresh_width", c2_lows, HOLD);
        joy1[4] = 1'b0; repeat (5) tick();

        // simultaneous sources
        joy0[5] = 1'b1; joy1[6] = 1'b1; tick();
        check("starts_same_edge", {start1_n, start2_n}, 2'b00);
        joy0[5] = 1'b0; joy1[6] = 1'b0; joy0[7] = 1'b1; c2_lows = 0; tick();
        check("coin_alt", coin1_n, 0);
        joy0[7] = 1'b0; repeat (10) tick();
        check("coin2_idle", c2_lows, 0);

        // random traffic, including back-to-back toggles
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 7) == 0) joy0[$urandom_range(0, 7)] ^= 1'b1;
            if ($urandom_range(0, 7) == 0) joy1[$urandom_range(0, 7)] ^= 1'b1;
            if ($urandom_range(0, 2) == 0)
                key(1'($urandom_range(0, 1)),
                    {1'($urandom_range(0, 3) == 0), codes[$urandom_range(0, 17)]});
            kb_flush = ($urandom_range(0, 39) == 0);
            tick();
        end
        joy0 = '0; joy1 = '0; kb_flush = 1'b0;
        repeat (12) tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
